// File: rtl/run_pkg.sv
// run_pkg: shared types and helpers for the run sequencer.
//   state_t    - 3-bit controller state encoding (also driven out on the state port)
//   run_mode_t - 2-bit run request sampled together with start
//   is_busy()  - true in the four phase states
//   entry_state() - first state of a run for a given mode
package run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_IMEM = 3'd1,
        ST_RX_DMEM = 3'd2,
        ST_EXEC    = 3'd3,
        ST_TX_DMEM = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_FULL = 2'd0,
        MODE_DATA = 2'd1,
        MODE_EXEC = 2'd2,
        MODE_RSVD = 2'd3
    } run_mode_t;

    function automatic logic is_busy(input state_t s);
        return (s inside {ST_RX_IMEM, ST_RX_DMEM, ST_EXEC, ST_TX_DMEM});
    endfunction

    // The reserved mode falls back to a full load.
    function automatic state_t entry_state(input run_mode_t m);
        case (m)
            MODE_DATA: return ST_RX_DMEM;
            MODE_EXEC: return ST_EXEC;
            default:   return ST_RX_IMEM;
        endcase
    endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: bundles the run controller's request/handshake signals and
// the UART/processor/memory port signals.
//   slave  - seen by run_sequencer (requests, done pulses, source ports in;
//            muxed ports, pulses, descriptors and status out)
//   master - seen by the surrounding system / testbench
interface run_sequencer_if #(
    parameter int CORE_COUNT  = 2,
    parameter int REG_WIDTH   = 12,
    parameter int DMEM_ADDR_W = 12,
    parameter int IMEM_ADDR_W = 8,
    parameter int TIME_W      = 26
);
    localparam int DATA_W = CORE_COUNT * REG_WIDTH;

    // requests and phase completion
    logic                   start;
    logic [1:0]             run_mode;
    logic                   imem_rx_done;
    logic                   dmem_rx_done;
    logic                   dmem_tx_done;
    logic                   proc_done;
    logic                   rx_byte_valid;
    logic                   ins_byte_valid;
    logic                   data_byte_valid;

    // data memory ports
    logic [DMEM_ADDR_W-1:0] uart_dmem_addr;
    logic [DATA_W-1:0]      uart_dmem_wdata;
    logic                   uart_dmem_we;
    logic [DMEM_ADDR_W-1:0] proc_dmem_addr;
    logic [DATA_W-1:0]      proc_dmem_wdata;
    logic                   proc_dmem_we;
    logic [DMEM_ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]      dmem_wdata;
    logic                   dmem_we;

    // instruction memory ports
    logic [IMEM_ADDR_W-1:0] uart_imem_addr;
    logic [IMEM_ADDR_W-1:0] proc_imem_addr;
    logic [IMEM_ADDR_W-1:0] imem_addr;

    // control pulses, descriptors, status
    logic                   proc_start;
    logic                   tx_start;
    logic [DMEM_ADDR_W-1:0] rx_end_addr;
    logic [DMEM_ADDR_W-1:0] tx_start_addr;
    logic [DMEM_ADDR_W-1:0] tx_end_addr;
    logic [2:0]             state;
    logic                   busy;
    logic [TIME_W-1:0]      exec_cycles;
    logic                   err;
    logic [2:0]             err_state;

    modport slave (
        input  start, run_mode, imem_rx_done, dmem_rx_done, dmem_tx_done, proc_done,
        input  rx_byte_valid,
        input  uart_dmem_addr, uart_dmem_wdata, uart_dmem_we,
        input  proc_dmem_addr, proc_dmem_wdata, proc_dmem_we,
        input  uart_imem_addr, proc_imem_addr,
        output ins_byte_valid, data_byte_valid,
        output dmem_addr, dmem_wdata, dmem_we, imem_addr,
        output proc_start, tx_start,
        output rx_end_addr, tx_start_addr, tx_end_addr,
        output state, busy, exec_cycles, err, err_state
    );

    modport master (
        output start, run_mode, imem_rx_done, dmem_rx_done, dmem_tx_done, proc_done,
        output rx_byte_valid,
        output uart_dmem_addr, uart_dmem_wdata, uart_dmem_we,
        output proc_dmem_addr, proc_dmem_wdata, proc_dmem_we,
        output uart_imem_addr, proc_imem_addr,
        input  ins_byte_valid, data_byte_valid,
        input  dmem_addr, dmem_wdata, dmem_we, imem_addr,
        input  proc_start, tx_start,
        input  rx_end_addr, tx_start_addr, tx_end_addr,
        input  state, busy, exec_cycles, err, err_state
    );

endinterface

// File: rtl/run_sequencer_phase_watchdog.sv
// phase_watchdog: per-phase stall detector.
//   clk, rst - clock, asynchronous active-high reset
//   clear    - zero the count (any state change)
//   enable   - count this cycle (busy phases)
//   timeout  - the count steps to all-ones at the end of this cycle
// A phase that never completes therefore lasts exactly 2**WDOG_W - 1 cycles.
module phase_watchdog #(
    parameter int WDOG_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam logic [WDOG_W-1:0] ALL_ONES  = '1;
    localparam logic [WDOG_W-1:0] LAST_STEP = ~(WDOG_W'(1));

    logic [WDOG_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != ALL_ONES)) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign timeout = enable && (count == LAST_STEP);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: top-level run controller of the multi-core matrix processor.
// Sequences instruction load, data load, execution and result upload, with
// data-only and execute-only re-runs, a per-phase watchdog and an error state.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - run_sequencer_if.slave: start/run_mode request, phase done
//              pulses, UART byte strobe gating, dmem/imem arbitration,
//              proc_start/tx_start pulses, captured result descriptors,
//              state/busy/err status and the execution cycle count.
module run_sequencer
    import run_pkg::*;
#(
    parameter int CORE_COUNT   = 2,
    parameter int REG_WIDTH    = 12,
    parameter int DMEM_ADDR_W  = 12,
    parameter int IMEM_ADDR_W  = 8,
    parameter int TIME_W       = 26,
    parameter int WDOG_W       = 24,
    parameter int RX_END_LOC   = 7,
    parameter int TX_START_LOC = 5,
    parameter int TX_END_LOC   = 8
) (
    input  logic             clk,
    input  logic             rst,
    run_sequencer_if.slave   bus
);
    localparam int DATA_W = CORE_COUNT * REG_WIDTH;
    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    state_t state;
    state_t state_next;
    logic   wdog_timeout;
    logic   entering_exec;
    logic   entering_tx;

    logic                   proc_start_q;
    logic                   tx_start_q;
    logic [TIME_W-1:0]      exec_q;
    logic [2:0]             err_state_q;
    logic [DMEM_ADDR_W-1:0] rx_end_q;
    logic [DMEM_ADDR_W-1:0] tx_start_q_addr;
    logic [DMEM_ADDR_W-1:0] tx_end_q;

    logic [DMEM_ADDR_W-1:0] dmem_addr_mux;
    logic [DATA_W-1:0]      dmem_wdata_mux;
    logic                   dmem_we_mux;
    logic [IMEM_ADDR_W-1:0] imem_addr_mux;

    // ------------------------------------------------------------------
    // Watchdog: restarts on every state change, counts only in busy phases.
    // ------------------------------------------------------------------
    phase_watchdog #(.WDOG_W(WDOG_W)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_next != state),
        .enable  (is_busy(state)),
        .timeout (wdog_timeout)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Completion is tested before the timeout so a done
    // pulse arriving in the timeout cycle still advances the run.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) state_next = entry_state(run_mode_t'(bus.run_mode));
            end
            ST_RX_IMEM: begin
                if (bus.imem_rx_done)   state_next = ST_RX_DMEM;
                else if (wdog_timeout)  state_next = ST_ERROR;
            end
            ST_RX_DMEM: begin
                if (bus.dmem_rx_done)   state_next = ST_EXEC;
                else if (wdog_timeout)  state_next = ST_ERROR;
            end
            ST_EXEC: begin
                if (bus.proc_done)      state_next = ST_TX_DMEM;
                else if (wdog_timeout)  state_next = ST_ERROR;
            end
            ST_TX_DMEM: begin
                if (bus.dmem_tx_done)   state_next = ST_DONE;
                else if (wdog_timeout)  state_next = ST_ERROR;
            end
            ST_ERROR: begin
                if (bus.start)          state_next = ST_IDLE;
            end
            default:                    state_next = ST_IDLE;
        endcase
    end

    assign entering_exec = (state_next == ST_EXEC)    && (state != ST_EXEC);
    assign entering_tx   = (state_next == ST_TX_DMEM) && (state != ST_TX_DMEM);

    // ------------------------------------------------------------------
    // State register and registered pulses/status. The start pulses are
    // flopped so they line up with the first cycle of the new phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            proc_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            exec_q       <= '0;
            err_state_q  <= '0;
        end else begin
            state        <= state_next;
            proc_start_q <= entering_exec;
            tx_start_q   <= entering_tx;

            // Execution timer: restart on entry, saturate instead of wrapping,
            // hold the last value between runs.
            if (entering_exec) begin
                exec_q <= '0;
            end else if ((state == ST_EXEC) && (exec_q != TIME_MAX)) begin
                exec_q <= exec_q + TIME_W'(1);
            end

            if ((state_next == ST_ERROR) && (state != ST_ERROR)) begin
                err_state_q <= state;
            end else if ((state == ST_ERROR) && (state_next == ST_IDLE)) begin
                err_state_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result descriptors: snooped from UART writes during the data load and
    // kept across runs so an execute-only run reuses them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_end_q        <= '0;
            tx_start_q_addr <= '0;
            tx_end_q        <= '0;
        end else if ((state == ST_RX_DMEM) && bus.uart_dmem_we) begin
            if (bus.uart_dmem_addr == DMEM_ADDR_W'(RX_END_LOC))
                rx_end_q <= bus.uart_dmem_wdata[DMEM_ADDR_W-1:0];
            if (bus.uart_dmem_addr == DMEM_ADDR_W'(TX_START_LOC))
                tx_start_q_addr <= bus.uart_dmem_wdata[DMEM_ADDR_W-1:0];
            if (bus.uart_dmem_addr == DMEM_ADDR_W'(TX_END_LOC))
                tx_end_q <= bus.uart_dmem_wdata[DMEM_ADDR_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Memory port arbitration: ports are parked at zero outside the phases
    // that own them, so no stray write can reach dmem.
    // ------------------------------------------------------------------
    always_comb begin
        dmem_addr_mux  = '0;
        dmem_wdata_mux = '0;
        dmem_we_mux    = 1'b0;
        imem_addr_mux  = '0;
        case (state)
            ST_RX_IMEM: begin
                imem_addr_mux  = bus.uart_imem_addr;
            end
            ST_RX_DMEM, ST_TX_DMEM: begin
                dmem_addr_mux  = bus.uart_dmem_addr;
                dmem_wdata_mux = bus.uart_dmem_wdata;
                dmem_we_mux    = bus.uart_dmem_we;
            end
            ST_EXEC: begin
                dmem_addr_mux  = bus.proc_dmem_addr;
                dmem_wdata_mux = bus.proc_dmem_wdata;
                dmem_we_mux    = bus.proc_dmem_we;
                imem_addr_mux  = bus.proc_imem_addr;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.dmem_addr       = dmem_addr_mux;
    assign bus.dmem_wdata      = dmem_wdata_mux;
    assign bus.dmem_we         = dmem_we_mux;
    assign bus.imem_addr       = imem_addr_mux;
    assign bus.ins_byte_valid  = bus.rx_byte_valid && (state == ST_RX_IMEM);
    assign bus.data_byte_valid = bus.rx_byte_valid && (state == ST_RX_DMEM);
    assign bus.proc_start      = proc_start_q;
    assign bus.tx_start        = tx_start_q;
    assign bus.rx_end_addr     = rx_end_q;
    assign bus.tx_start_addr   = tx_start_q_addr;
    assign bus.tx_end_addr     = tx_end_q;
    assign bus.state           = state;
    assign bus.busy            = is_busy(state);
    assign bus.exec_cycles     = exec_q;
    assign bus.err             = (state == ST_ERROR);
    assign bus.err_state       = err_state_q;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Parametrised top-level run controller for the multi-core matrix processor.
- Sequences UART instruction load, UART data load, processor execution and UART result upload.
- Owns the data/instruction memory port arbitration, captures the result address descriptor words, and times execution.
- Unlike the current fixed flow, supports partial re-runs (data-only or execute-only), a per-phase watchdog with an error state, and parametrised core count and memory geometry.

Parameters:
- CORE_COUNT, 2, number of cores; data word = CORE_COUNT*REG_WIDTH.
- REG_WIDTH, 12, per-core register width.
- DMEM_ADDR_W, 12, data memory address width.
- IMEM_ADDR_W, 8, instruction memory address width.
- TIME_W, 26, execution cycle counter width.
- WDOG_W, 24, watchdog counter width; timeout when the counter reaches all-ones.
- RX_END_LOC, 7, dmem address holding the Q end address.
- TX_START_LOC, 5, dmem address holding the R start address.
- TX_END_LOC, 8, dmem address holding the R end address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  synchronous one-cycle request.
- run_mode  in  2  0 full load, 1 data-only, 2 execute-only, 3 reserved (treated as 0); sampled with start.
- imem_rx_done  in  1  pulse: instruction memory fully received.
- dmem_rx_done  in  1  pulse: data memory fully received.
- dmem_tx_done  in  1  pulse: result upload finished.
- proc_done  in  1  processor finished.
- rx_byte_valid  in  1  new UART byte strobe.
- ins_byte_valid  out  1  rx_byte_valid gated to RX_IMEM.
- data_byte_valid  out  1  rx_byte_valid gated to RX_DMEM.
- uart_dmem_addr / uart_dmem_wdata / uart_dmem_we  in  DMEM_ADDR_W / CORE_COUNT*REG_WIDTH / 1  UART-side dmem port.
- proc_dmem_addr / proc_dmem_wdata / proc_dmem_we  in  same  processor-side dmem port.
- dmem_addr / dmem_wdata / dmem_we  out  same  muxed dmem port.
- uart_imem_addr, proc_imem_addr  in  IMEM_ADDR_W  imem addresses.
- imem_addr  out  IMEM_ADDR_W  muxed imem address.
- proc_start  out  1  one-cycle processor start pulse.
- tx_start  out  1  one-cycle upload start pulse.
- rx_end_addr, tx_start_addr, tx_end_addr  out  DMEM_ADDR_W  captured descriptors.
- state  out  3  current state encoding.
- busy  out  1  high in RX_IMEM, RX_DMEM, EXEC, TX_DMEM.
- exec_cycles  out  TIME_W  execution time.
- err  out  1  high in ERROR.
- err_state  out  3  state in which the watchdog fired.

Behaviour:
- Reset values: all outputs 0; state = IDLE.
- State encoding: IDLE=0, RX_IMEM=1, RX_DMEM=2, EXEC=3, TX_DMEM=4, DONE=5, ERROR=6.
- Start handling: start is honoured in IDLE or DONE only; it is ignored while busy.
- Mode on start:
  - mode 0 (or 3) -> RX_IMEM.
  - mode 1 -> RX_DMEM.
  - mode 2 -> EXEC, with proc_start asserted in the same cycle as the transition.
- Phase transitions:
  - RX_IMEM + imem_rx_done -> RX_DMEM.
  - RX_DMEM + dmem_rx_done -> EXEC; proc_start is a registered pulse in the transition cycle.
  - EXEC + proc_done -> TX_DMEM; tx_start pulses in the same cycle.
  - TX_DMEM + dmem_tx_done -> DONE.
- Watchdog:
  - Clears on every state change; increments each cycle in the busy states.
  - Reaching all-ones -> ERROR, with err_state = the state it fired in.
  - If a completion event and the timeout occur in the same cycle, the completion event wins.
- ERROR: stays until start, which returns to IDLE and clears err/err_state; reset also exits ERROR.
- dmem mux:
  - UART port in RX_DMEM and TX_DMEM; processor port in EXEC.
  - Elsewhere, address/data are 0 and we is 0.
  - dmem_we is never asserted outside these three states.
- imem mux: UART address in RX_IMEM, processor address in EXEC, else 0.
- Descriptor capture:
  - In RX_DMEM, when uart_dmem_we is high and uart_dmem_addr matches a *_LOC, the matching register takes uart_dmem_wdata[DMEM_ADDR_W-1:0].
  - The registers retain their values across runs, so mode 2 reuses them.
  - They are cleared only by rst.
- exec_cycles:
  - Cleared on entry to EXEC; increments each EXEC cycle and saturates at all-ones (no wrap).
  - Holds its value after EXEC until the next EXEC entry.
- Reset mid-operation: asserting rst in any state forces IDLE and zero outputs asynchronously; descriptors are cleared.

Decomposition:
- Package run_pkg: state_t enum (3-bit, values above) and run_mode_t enum.
- Sub-module phase_watchdog (clear, enable, timeout output, WDOG_W parameter), instantiated once.
- Port muxes and descriptor capture stay inline.

Test Plan:
- rst, then start with mode 0, driving each done pulse 10 cycles apart -> states 1, 2, 3, 4, 5; proc_start and tx_start are each high exactly 1 cycle; exec_cycles = 10.
- In RX_DMEM, write 0x00A5 to addr 5, 0x00B0 to addr 8 and 0x0040 to addr 7 -> tx_start_addr=0x0A5, tx_end_addr=0x0B0, rx_end_addr=0x040.
- From DONE, start with mode 2 -> EXEC directly with proc_start pulse, descriptors unchanged; start with mode 1 -> RX_DMEM.
- With WDOG_W=4, withhold dmem_rx_done -> ERROR after 15 cycles in RX_DMEM, err_state=2, dmem_we=0; start -> IDLE with err=0.
- With TIME_W=3 and EXEC lasting 20 cycles -> exec_cycles=7 (saturated).
- Assert rst for 1 cycle mid-EXEC -> state=0, all outputs 0, descriptors 0; a start pulse during EXEC is ignored.
